// File: rtl/julia_pkg.sv
// rtl/julia_pkg.sv - shared pixel types and widths for the Julia search, worker and writer blocks
package julia_pkg;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } pixel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - small power-of-two pixel buffer with push/pop/clear and a registered full flag
module pixel_fifo
    import julia_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   clear,
    input  logic   push,
    input  pixel_t push_data,
    input  logic   pop,
    output pixel_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    pixel_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            do_push, do_pop;

    // Full is the registered flag, so a same-cycle pop never frees room for a push.
    assign do_push = push & ~full_q & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign empty   = (count_q == '0);
    assign full    = full_q;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
        full_d = (count_d == CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffers selected pixels and writes them to frame memory over Avalon-MM
module pixel_writer
    import julia_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_PIXELS = 307200
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              found,
    input  logic [PIX_W-1:0]                  sel_data,
    input  logic [ADDR_W-1:0]                 sel_address,
    output logic                              accept,
    input  logic                              clear,
    output logic [ADDR_W-1:0]                 m_address,
    output logic [PIX_W-1:0]                  m_writedata,
    output logic                              m_write,
    input  logic                              m_waitrequest,
    output logic                              fifo_full,
    output logic [$clog2(NUM_PIXELS+1)-1:0]   pix_count,
    output logic                              frame_done
);

    localparam int CNT_W = $clog2(NUM_PIXELS + 1);

    wr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  m_address_q, m_address_d;
    logic [PIX_W-1:0]   m_writedata_q, m_writedata_d;
    logic               m_write_q, m_write_d;
    logic [CNT_W-1:0]   pix_count_q, pix_count_d;
    logic               frame_done_q, frame_done_d;

    pixel_t             head;
    logic               fifo_empty;
    logic               pop;
    logic               xfer_done;

    assign accept    = found & ~fifo_full & ~clear;
    assign xfer_done = m_write_q & ~m_waitrequest;

    pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .push      (accept),
        .push_data ('{addr: sel_address, data: sel_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!clear && !fifo_empty) state_d = ST_WRITE;
            ST_WRITE: if (!m_waitrequest && (clear || fifo_empty)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A clear discards buffered pixels, so no new head is loaded that cycle.
    always_comb begin
        pop           = 1'b0;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        m_write_d     = m_write_q;
        case (state_q)
            ST_IDLE: begin
                if (!clear && !fifo_empty) pop = 1'b1;
            end
            ST_WRITE: begin
                if (!m_waitrequest) begin
                    if (!clear && !fifo_empty) pop = 1'b1;
                    else                       m_write_d = 1'b0;
                end
            end
            default: m_write_d = 1'b0;
        endcase
        if (pop) begin
            m_address_d   = head.addr;
            m_writedata_d = head.data;
            m_write_d     = 1'b1;
        end
    end

    always_comb begin
        pix_count_d  = pix_count_q;
        frame_done_d = 1'b0;
        if (clear) begin
            pix_count_d = '0;
        end else if (xfer_done) begin
            if (pix_count_q == CNT_W'(NUM_PIXELS - 1)) begin
                pix_count_d  = '0;
                frame_done_d = 1'b1;
            end else begin
                pix_count_d = pix_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_address_q   <= '0;
            m_writedata_q <= '0;
            m_write_q     <= 1'b0;
            pix_count_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            m_write_q     <= m_write_d;
            pix_count_q   <= pix_count_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign m_write     = m_write_q;
    assign pix_count   = pix_count_q;
    assign frame_done  = frame_done_q;

endmodule
